// File: rtl/sipo_deser_if.sv
// ----------------------------------------------------------------------------
// Module   : sipo_deser_if
// Brief    : Serial input and word-wide valid/ready output bundle for sipo_deser
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface sipo_deser_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             si;
  logic             si_en;
  logic             sync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport slave (
    input  si, si_en, sync, po_ready,
    output po, po_valid, bit_cnt, overrun
  );

  modport master (
    output si, si_en, sync, po_ready,
    input  po, po_valid, bit_cnt, overrun
  );
endinterface

`default_nettype wire

// File: rtl/sipo_deser.sv
// ----------------------------------------------------------------------------
// Module   : sipo_deser
// Brief    : Serial-in/parallel-out deserialiser with holding register and overrun flag
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire             clk,
  input  wire             rst,
  sipo_deser_if.slave     bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shift_val;
  logic             shift_en;
  logic             complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_val = {sr_q[WIDTH-2:0], bus.si};
    end else begin : g_lsb_first
      assign shift_val = {bus.si, sr_q[WIDTH-1:1]};
    end
  endgenerate

  // sync suppresses both shifting and completion on its edge
  assign shift_en = bus.si_en && !bus.sync;
  assign complete = shift_en && (bit_cnt_q == LAST);

  always_comb begin
    sr_d       = sr_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;
    bit_cnt_d  = bit_cnt_q;
    overrun_d  = overrun_q;

    if (po_valid_q && bus.po_ready) begin
      po_valid_d = 1'b0;
    end

    if (bus.sync) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      sr_d      = shift_val;
      bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
    end

    // A completing word may replace one being accepted on the same edge
    if (complete) begin
      if (!po_valid_q || bus.po_ready) begin
        po_d       = shift_val;
        po_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      bit_cnt_q  <= bit_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign bus.bit_cnt  = bit_cnt_q;
  assign bus.overrun  = overrun_q;

endmodule

`default_nettype wire
